// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction handshake and ALU operand/result bundle for alu_issue_ctrl
interface alu_issue_ctrl_if #(
  parameter int DW = 16
);
  logic          instr_valid;
  logic          instr_ready;
  logic [23:0]   instr;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [4:0]    alu_code;
  logic          alu_coe;
  logic [DW-1:0] alu_c;
  logic          alu_vout;
  logic          alu_cout;

  modport slave (
    input  instr_valid, instr, alu_c, alu_vout, alu_cout,
    output instr_ready, alu_a, alu_b, alu_code, alu_coe
  );

  modport master (
    output instr_valid, instr, alu_c, alu_vout, alu_cout,
    input  instr_ready, alu_a, alu_b, alu_code, alu_coe
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - 4-cycle issue/retire sequencer for the 16-bit ALU with an 8x16 register file
// Optional macro ALU_ISSUE_STICKY_EN makes flag_v/flag_c sticky until stk_clr or rst.
module alu_issue_ctrl #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_ctrl_if.slave     bus,
  input  logic                host_we,
  input  logic [2:0]          host_addr,
  input  logic [DW-1:0]       host_wdata,
  output logic [DW-1:0]       host_rdata,
  output logic                done,
  output logic                err,
  output logic                flag_v,
  output logic                flag_c,
  output logic                flag_z,
  input  logic                stk_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_RETIRE
  } state_t;

  state_t        r_state;
  logic [23:0]   r_instr;
  logic [DW-1:0] r_regs [NREG];
  logic [DW-1:0] r_res;
  logic          r_res_v;
  logic          r_res_cout;
  logic          r_illegal;
  logic          r_ready;
  logic          r_done;
  logic          r_err;
  logic          r_flag_v;
  logic          r_flag_c;
  logic          r_flag_z;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [4:0]    r_alu_code;
  logic          r_alu_coe;

  logic [4:0]    w_op;
  logic [2:0]    w_rd;
  logic [2:0]    w_rs1;
  logic [2:0]    w_rs2;
  logic          w_coe_n;
  logic          w_imm_sel;
  logic [DW-1:0] w_imm_ext;
  logic          w_legal;
  logic          w_retire_we;
  logic          w_host_we;

  assign w_op      = r_instr[23:19];
  assign w_rd      = r_instr[18:16];
  assign w_rs1     = r_instr[15:13];
  assign w_rs2     = r_instr[12:10];
  assign w_coe_n   = r_instr[9];
  assign w_imm_sel = r_instr[8];
  assign w_imm_ext = {{(DW-8){r_instr[7]}}, r_instr[7:0]};

  assign w_legal = (w_op <= 5'd5) ||
                   ((w_op >= 5'd8) && (w_op <= 5'd10)) ||
                   (w_op == 5'd12) ||
                   ((w_op >= 5'd16) && (w_op <= 5'd19)) ||
                   ((w_op >= 5'd24) && (w_op <= 5'd29));

  // Writeback takes priority over a host write aimed at the same register.
  assign w_retire_we = (r_state == S_RETIRE) && !r_illegal;
  assign w_host_we   = host_we && !(w_retire_we && (host_addr == w_rd));

`ifndef ALU_ISSUE_STICKY_EN
  logic w_unused_stk_clr;
  assign w_unused_stk_clr = stk_clr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_instr    <= '0;
      r_res      <= '0;
      r_res_v    <= 1'b0;
      r_res_cout <= 1'b0;
      r_illegal  <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_flag_v   <= 1'b0;
      r_flag_c   <= 1'b0;
      r_flag_z   <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_code <= '0;
      r_alu_coe  <= 1'b1;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (w_host_we) begin
        r_regs[host_addr] <= host_wdata;
      end

`ifdef ALU_ISSUE_STICKY_EN
      if (stk_clr) begin
        r_flag_v <= 1'b0;
        r_flag_c <= 1'b0;
      end
`endif

      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            r_instr <= bus.instr;
            r_ready <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= S_RETIRE;
          end else begin
            r_illegal  <= 1'b0;
            r_alu_code <= w_op;
            r_alu_a    <= r_regs[w_rs1];
            r_alu_b    <= w_imm_sel ? w_imm_ext : r_regs[w_rs2];
            r_alu_coe  <= w_coe_n;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res      <= bus.alu_c;
          r_res_v    <= bus.alu_vout;
          r_res_cout <= bus.alu_cout;
          r_done     <= 1'b1;
          r_state    <= S_RETIRE;
        end
        S_RETIRE: begin
          if (!r_illegal) begin
            r_regs[w_rd] <= r_res;
`ifdef ALU_ISSUE_STICKY_EN
            // A same-cycle clear drops the old sticky value but keeps this retire's.
            r_flag_v <= (r_flag_v & ~stk_clr) | r_res_v;
            r_flag_c <= (r_flag_c & ~stk_clr) | r_res_cout;
`else
            r_flag_v <= r_res_v;
            r_flag_c <= r_res_cout;
`endif
            r_flag_z <= (r_res == '0);
          end
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_code    = r_alu_code;
  assign bus.alu_coe     = r_alu_coe;
  assign host_rdata      = r_regs[host_addr];
  assign done            = r_done;
  assign err             = r_err;
  assign flag_v          = r_flag_v;
  assign flag_c          = r_flag_c;
  assign flag_z          = r_flag_z;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed bench for alu_issue_ctrl with a small behavioural ALU
module tb_alu_issue_ctrl;
  logic        clk;
  logic        rst;
  logic        host_we;
  logic [2:0]  host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        done;
  logic        err;
  logic        flag_v;
  logic        flag_c;
  logic        flag_z;
  logic        stk_clr;

  int n_total = 0;
  int n_pass  = 0;

  alu_issue_ctrl_if #(.DW(16)) bus ();

  alu_issue_ctrl #(.NREG(8), .DW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .done       (done),
    .err        (err),
    .flag_v     (flag_v),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .stk_clr    (stk_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: 0 add, 1 addu (no overflow), 2 sub, 8 and; coe is active low.
  logic [16:0] m_sum;
  logic        m_v;
  always_comb begin
    m_sum = 17'd0;
    m_v   = 1'b0;
    case (bus.alu_code)
      5'd0: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_v   = (bus.alu_a[15] == bus.alu_b[15]) && (m_sum[15] != bus.alu_a[15]);
      end
      5'd1: m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      5'd2: begin
        m_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        m_v   = (bus.alu_a[15] != bus.alu_b[15]) && (m_sum[15] != bus.alu_a[15]);
      end
      5'd8: m_sum = {1'b0, bus.alu_a & bus.alu_b};
      default: m_sum = 17'd0;
    endcase
    bus.alu_c    = m_sum[15:0];
    bus.alu_vout = m_v;
    bus.alu_cout = ~bus.alu_coe & m_sum[16];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [15:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    host_addr = a;
    #1;
    chk(tag, host_rdata, exp);
  endtask

  // Presents one instruction; returns one cycle after the handshake edge (DECODE).
  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic coe_n, input logic imm_sel,
                       input logic [7:0] imm8);
    bus.instr_valid = 1'b1;
    bus.instr       = {op, rd, rs1, rs2, coe_n, imm_sel, imm8};
    tick();
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 24'h0;
    host_we = 1'b0;
    host_addr = 3'd0;
    host_wdata = 16'h0;
    stk_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_flags", {flag_v, flag_c, flag_z}, 0);
    chk("rst_alu_coe", bus.alu_coe, 1);
    chk("rst_alu_code", bus.alu_code, 0);
    chk("rst_alu_ab", {bus.alu_a, bus.alu_b}, 0);

    host_wr(3'd1, 16'h7FFF);
    host_wr(3'd2, 16'h0001);

    issue(5'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 8'h00);
    chk("add_c1_done", done, 0);
    tick();
    chk("add_exec_code", bus.alu_code, 5'd0);
    chk("add_exec_a", bus.alu_a, 16'h7FFF);
    chk("add_exec_b", bus.alu_b, 16'h0001);
    chk("add_exec_coe", bus.alu_coe, 0);
    chk("add_c2_done", done, 0);
    tick();
    chk("add_c3_done", done, 1);
    chk("add_c3_err", err, 0);
    chk("add_c3_ready", bus.instr_ready, 0);
    tick();
    chk("add_c4_ready", bus.instr_ready, 1);
    chk("add_c4_done", done, 0);
    chk("add_flag_v", flag_v, 1);
    chk("add_flag_c", flag_c, 0);
    chk("add_flag_z", flag_z, 0);
    chk_reg("add_r3", 3'd3, 16'h8000);

    host_wr(3'd1, 16'hFFFF);
    issue(5'd1, 3'd4, 3'd1, 3'd0, 1'b0, 1'b1, 8'h01);
    tick();
    chk("addu_exec_b", bus.alu_b, 16'h0001);
    tick();
    tick();
    chk_reg("addu_r4", 3'd4, 16'h0000);
    chk("addu_flag_c", flag_c, 1);
    chk("addu_flag_z", flag_z, 1);
    chk("addu_flag_v", flag_v, 0);

    issue(5'd1, 3'd4, 3'd1, 3'd0, 1'b1, 1'b1, 8'h01);
    tick();
    chk("addu_ncoe_exec_coe", bus.alu_coe, 1);
    tick();
    tick();
    chk("addu_ncoe_flag_c", flag_c, 0);
    chk("addu_ncoe_flag_z", flag_z, 1);

    issue(5'd8, 3'd5, 3'd1, 3'd0, 1'b0, 1'b1, 8'h80);
    tick();
    chk("sext_80", bus.alu_b, 16'hFF80);
    tick();
    tick();
    chk_reg("and_r5", 3'd5, 16'hFF80);
    chk("and_flag_z", flag_z, 0);

    issue(5'd8, 3'd6, 3'd1, 3'd0, 1'b0, 1'b1, 8'h7F);
    tick();
    chk("sext_7f", bus.alu_b, 16'h007F);
    tick();
    tick();
    chk_reg("and_r6", 3'd6, 16'h007F);

    issue(5'd6, 3'd5, 3'd2, 3'd2, 1'b1, 1'b0, 8'h00);
    chk("ill_c1_done", done, 0);
    tick();
    chk("ill_c2_done", done, 1);
    chk("ill_c2_err", err, 1);
    chk("ill_alu_a", bus.alu_a, 16'hFFFF);
    chk("ill_alu_b", bus.alu_b, 16'h007F);
    chk("ill_alu_code", bus.alu_code, 5'd8);
    chk("ill_alu_coe", bus.alu_coe, 0);
    tick();
    chk("ill_c3_err", err, 0);
    chk("ill_c3_ready", bus.instr_ready, 1);
    chk("ill_flags", {flag_v, flag_c, flag_z}, 0);
    chk_reg("ill_r5", 3'd5, 16'hFF80);

    issue(5'd8, 3'd2, 3'd1, 3'd0, 1'b0, 1'b1, 8'h0F);
    tick();
    tick();
    host_we = 1'b1;
    host_addr = 3'd2;
    host_wdata = 16'h1234;
    tick();
    host_we = 1'b0;
    chk_reg("wb_wins_r2", 3'd2, 16'h000F);

    issue(5'd8, 3'd2, 3'd1, 3'd0, 1'b0, 1'b1, 8'h0F);
    tick();
    tick();
    host_we = 1'b1;
    host_addr = 3'd6;
    host_wdata = 16'h1234;
    tick();
    host_we = 1'b0;
    chk_reg("host_r6", 3'd6, 16'h1234);
    chk_reg("wb_r2", 3'd2, 16'h000F);

    host_wr(3'd1, 16'h7FFF);
    issue(5'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    tick();
    chk("stk_first_v", flag_v, 1);
    chk_reg("stk_r3", 3'd3, 16'h800E);
    issue(5'd0, 3'd3, 3'd2, 3'd2, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    tick();
`ifdef ALU_ISSUE_STICKY_EN
    chk("stk_second_v", flag_v, 1);
`else
    chk("stk_second_v", flag_v, 0);
`endif
    chk_reg("stk_r3b", 3'd3, 16'h001E);
    stk_clr = 1'b1;
    tick();
    stk_clr = 1'b0;
    chk("stk_clr_v", flag_v, 0);

    issue(5'd2, 3'd7, 3'd1, 3'd2, 1'b0, 1'b0, 8'h00);
    tick();
    chk("sub_exec_code", bus.alu_code, 5'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_alu_code", bus.alu_code, 0);
    chk("arst_alu_a", bus.alu_a, 0);
    chk("arst_alu_coe", bus.alu_coe, 1);
    chk("arst_done", done, 0);
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) done_seen++;
    end
    chk("arst_no_done", done_seen, 0);
    chk("arst_ready", bus.instr_ready, 1);
    chk_reg("arst_r7", 3'd7, 16'h0000);

    host_wr(3'd1, 16'h0005);
    host_wr(3'd2, 16'h0003);
    issue(5'd2, 3'd7, 3'd1, 3'd2, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    tick();
    chk_reg("post_rst_r7", 3'd7, 16'h0002);
    chk("post_rst_z", flag_z, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
